// File: rtl/cska_addsub_pipe.sv
// cska_addsub_pipe: pipelined carry-skip adder/subtractor with valid/ready handshake and global stall
module cska_addsub_pipe #(
   parameter int WIDTH  = 26,
   parameter int BLOCK  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             V
);
   localparam int SEG = (WIDTH + STAGES - 1) / STAGES;
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic adv;

   // Carry-skip add over bits [lo,hi); returns {carry into MSB, carry out, sum bits in place}
   function automatic logic [WIDTH+1:0] seg_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic cin, input int lo, input int hi);
      logic [WIDTH-1:0] s;
      logic gc, rc, gp, cm;
      s  = '0;
      gc = cin;
      rc = cin;
      gp = 1'b1;
      cm = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (i >= lo && i < hi) begin
            if (i == WIDTH - 1) cm = rc;
            s[i] = a[i] ^ b[i] ^ rc;
            rc   = (a[i] & b[i]) | (rc & (a[i] ^ b[i]));
            gp   = gp & (a[i] ^ b[i]);
            if ((i - lo) % BLOCK == BLOCK - 1 || i == hi - 1) begin
               gc = gp ? gc : rc;
               rc = gc;
               gp = 1'b1;
            end
         end
      end
      return {cm, gc, s};
   endfunction

   for (genvar k = 0; k < STAGES; k++) begin : g_st
      localparam int LO = (k * SEG < WIDTH) ? k * SEG : WIDTH;
      localparam int HI = (k == STAGES - 1) ? WIDTH : (((k + 1) * SEG < WIDTH) ? (k + 1) * SEG : WIDTH);
      localparam logic HAS_MSB = (LO <= WIDTH - 1) && (HI > WIDTH - 1);
      localparam logic [WIDTH-1:0] LO_MASK = (ONE << LO) - ONE;
      localparam logic [WIDTH-1:0] HI_MASK = ~((ONE << HI) - ONE);

      logic [WIDTH-1:0] a_i, b_i, s_i, s_d, s_q;
      logic             v_i, c_i, m_i, v_d, v_q, c_d, c_q, m_d, m_q;
      logic [WIDTH+1:0] r;

      if (k == 0) begin : g_in
         assign a_i = in1;
         assign b_i = sub ? ~in2 : in2;
         assign c_i = sub;
         assign v_i = in_valid;
         assign s_i = '0;
         assign m_i = 1'b0;
      end else begin : g_link
         assign a_i = g_st[k-1].g_fwd.a_q;
         assign b_i = g_st[k-1].g_fwd.b_q;
         assign c_i = g_st[k-1].c_q;
         assign v_i = g_st[k-1].v_q;
         assign s_i = g_st[k-1].s_q;
         assign m_i = g_st[k-1].m_q;
      end

      always_comb begin
         r   = seg_add(a_i, b_i, c_i, LO, HI);
         v_d = v_i;
         c_d = r[WIDTH];
         m_d = HAS_MSB ? r[WIDTH+1] : m_i;
         s_d = (s_i & LO_MASK) | r[WIDTH-1:0];
      end

      always_ff @(posedge clk)
         if (!rst_n) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            m_q <= 1'b0;
            s_q <= '0;
         end else if (adv) begin
            v_q <= v_d;
            c_q <= c_d;
            m_q <= m_d;
            s_q <= s_d;
         end

      // Only operand bits above this segment travel on
      if (k < STAGES - 1) begin : g_fwd
         logic [WIDTH-1:0] a_d, a_q, b_d, b_q;
         always_comb begin
            a_d = a_i & HI_MASK;
            b_d = b_i & HI_MASK;
         end
         always_ff @(posedge clk)
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (adv) begin
               a_q <= a_d;
               b_q <= b_d;
            end
      end
   end

   always_comb begin
      out_valid = g_st[STAGES-1].v_q;
      S         = g_st[STAGES-1].s_q;
      Cout      = g_st[STAGES-1].c_q;
      V         = g_st[STAGES-1].m_q ^ g_st[STAGES-1].c_q;
      adv       = !out_valid || out_ready;
      in_ready  = adv;
   end
endmodule

// File: tb/tb_cska_addsub_pipe.sv
// tb_cska_addsub_pipe: directed and randomized parameter-sweep checks against an arithmetic reference
module tb_cska_addsub_pipe;
   logic clk, rst_n, go;
   int   n_tests, n_fail, done;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference result packed as {V, Cout, S}, from plain integer arithmetic
   function automatic logic [63:0] model(input int w, input longint a, input longint b, input logic sb);
      longint m, h, r, sa, sbv, t;
      logic   co, v;
      m   = longint'(1) << w;
      h   = m / 2;
      r   = sb ? a - b : a + b;
      co  = sb ? (a >= b) : (r >= m);
      sa  = a >= h ? a - m : a;
      sbv = b >= h ? b - m : b;
      t   = sb ? sa - sbv : sa + sbv;
      v   = (t >= h) || (t < -h);
      r   = r < 0 ? r + m : (r >= m ? r - m : r);
      return 64'(r) | (64'(co) << w) | (64'(v) << (w + 1));
   endfunction

   logic        d_iv, d_ir, d_sub, d_ov, d_or, d_co, d_v;
   logic [25:0] d_a, d_b, d_s;
   cska_addsub_pipe #(.WIDTH(26), .BLOCK(4), .STAGES(2)) u_d (
      .clk(clk), .rst_n(rst_n), .in_valid(d_iv), .in_ready(d_ir), .in1(d_a), .in2(d_b), .sub(d_sub),
      .out_valid(d_ov), .out_ready(d_or), .S(d_s), .Cout(d_co), .V(d_v));

   logic       e_iv, e_ir, e_sub, e_ov, e_or, e_co, e_v;
   logic [7:0] e_a, e_b, e_s;
   cska_addsub_pipe #(.WIDTH(8), .BLOCK(3), .STAGES(3)) u_e (
      .clk(clk), .rst_n(rst_n), .in_valid(e_iv), .in_ready(e_ir), .in1(e_a), .in2(e_b), .sub(e_sub),
      .out_valid(e_ov), .out_ready(e_or), .S(e_s), .Cout(e_co), .V(e_v));

   for (genvar i = 0; i < 5; i++) begin : g_w
      for (genvar j = 0; j < 4; j++) begin : g_b
         for (genvar k = 0; k < 3; k++) begin : g_s
            localparam int W  = (i == 0) ? 8 : (i == 1) ? 9 : (i == 2) ? 10 : (i == 3) ? 25 : 26;
            localparam int BL = (j == 0) ? 1 : (j == 1) ? 3 : (j == 2) ? 4 : W;
            localparam int ST = k + 1;
            logic         iv, ir, sb, ov, orr, co, vv;
            logic [W-1:0] a, b, s;
            cska_addsub_pipe #(.WIDTH(W), .BLOCK(BL), .STAGES(ST)) u (
               .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .in1(a), .in2(b), .sub(sb),
               .out_valid(ov), .out_ready(orr), .S(s), .Cout(co), .V(vv));
            initial begin : run
               logic [63:0] q[$];
               logic        taken;
               string       tag;
               tag   = $sformatf("sw_w%0d_b%0d_s%0d", W, BL, ST);
               iv    = 1'b0;
               orr   = 1'b1;
               a     = '0;
               b     = '0;
               sb    = 1'b0;
               taken = 1'b0;
               wait (go);
               for (int c = 0; c < 150; c++) begin
                  @(negedge clk);
                  if (!iv || taken) begin
                     a  = W'($urandom);
                     b  = W'($urandom);
                     sb = 1'($urandom);
                     iv = c < 120 && $urandom_range(3) != 0;
                  end
                  orr = c >= 120 || $urandom_range(3) != 0;
                  #1;
                  if (ov) begin
                     if (q.size() == 0) chk({tag, "_extra"}, 64'(ov), 64'h0);
                     else begin
                        chk(tag, 64'({vv, co, s}), q[0]);
                        if (orr) void'(q.pop_front());
                     end
                  end
                  taken = iv && ir;
                  if (taken) q.push_back(model(W, longint'(a), longint'(b), sb));
               end
               chk({tag, "_drain"}, 64'(q.size()), 64'h0);
               done++;
            end
         end
      end
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      done    = 0;
      go      = 1'b0;
      rst_n   = 1'b0;
      d_iv = 1'b0; d_a = '0; d_b = '0; d_sub = 1'b0; d_or = 1'b1;
      e_iv = 1'b0; e_a = '0; e_b = '0; e_sub = 1'b0; e_or = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_ov", 64'(d_ov), 64'h0);
      chk("rst_s", 64'(d_s), 64'h0);
      chk("rst_co", 64'(d_co), 64'h0);
      chk("rst_v", 64'(d_v), 64'h0);
      chk("rst_ir", 64'(d_ir), 64'h1);

      @(negedge clk);
      d_iv = 1'b1; d_a = 26'h3FFFFFF; d_b = 26'h1; d_sub = 1'b0;
      #1 chk("lat_ir", 64'(d_ir), 64'h1);
      @(negedge clk);
      d_iv = 1'b0;
      #1 chk("lat_early", 64'(d_ov), 64'h0);
      @(negedge clk);
      #1;
      chk("lat_ov", 64'(d_ov), 64'h1);
      chk("skip_res", 64'({d_v, d_co, d_s}), 64'h4000000);

      @(negedge clk);
      d_iv = 1'b1; d_a = 26'd5; d_b = 26'd7; d_sub = 1'b1;
      @(negedge clk);
      d_a = 26'd7; d_b = 26'd5;
      @(negedge clk);
      d_iv = 1'b0;
      #1;
      chk("sub1_ov", 64'(d_ov), 64'h1);
      chk("sub1_res", 64'({d_v, d_co, d_s}), 64'h3FFFFFE);
      @(negedge clk);
      #1;
      chk("sub2_ov", 64'(d_ov), 64'h1);
      chk("sub2_res", 64'({d_v, d_co, d_s}), 64'h4000002);
      @(negedge clk);
      #1 chk("sub_drain", 64'(d_ov), 64'h0);

      @(negedge clk);
      e_iv = 1'b1; e_a = 8'h7F; e_b = 8'h01; e_sub = 1'b0;
      @(negedge clk);
      e_a = 8'h80; e_b = 8'h01; e_sub = 1'b1;
      @(negedge clk);
      e_iv = 1'b0;
      #1 chk("ovf_early", 64'(e_ov), 64'h0);
      @(negedge clk);
      #1 chk("ovf_add", 64'({e_ov, e_v, e_co, e_s}), 64'h680);
      @(negedge clk);
      #1 chk("ovf_sub", 64'({e_ov, e_v, e_co, e_s}), 64'h77F);

      begin : bp
         logic [63:0] dq[$];
         logic [25:0] ba[6], bb[6];
         logic        bs[6];
         int          nb, got;
         for (int n = 0; n < 6; n++) begin
            ba[n] = 26'($urandom);
            bb[n] = 26'($urandom);
            bs[n] = 1'($urandom);
         end
         nb  = 0;
         got = 0;
         for (int c = 0; c < 24 && got < 6; c++) begin
            @(negedge clk);
            d_or = !(c >= 3 && c <= 5);
            d_iv = nb < 6;
            if (nb < 6) begin
               d_a = ba[nb]; d_b = bb[nb]; d_sub = bs[nb];
            end
            #1;
            if (c >= 3 && c <= 5) chk("bp_in_ready", 64'(d_ir), 64'h0);
            if (d_ov) begin
               if (dq.size() == 0) chk("bp_extra", 64'(d_ov), 64'h0);
               else begin
                  chk("bp_res", 64'({d_v, d_co, d_s}), dq[0]);
                  if (d_or) begin
                     void'(dq.pop_front());
                     got++;
                  end
               end
            end
            if (d_iv && d_ir) begin
               dq.push_back(model(26, longint'(ba[nb]), longint'(bb[nb]), bs[nb]));
               nb++;
            end
         end
         d_iv = 1'b0;
         d_or = 1'b1;
         chk("bp_count", 64'(got), 64'h6);
      end

      @(negedge clk);
      d_iv = 1'b1; d_a = 26'($urandom); d_b = 26'($urandom); d_sub = 1'b0;
      @(negedge clk);
      d_a = 26'($urandom); d_b = 26'($urandom); d_sub = 1'b1;
      @(negedge clk);
      d_iv  = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mrst_ov", 64'(d_ov), 64'h0);
      chk("mrst_s", 64'(d_s), 64'h0);
      chk("mrst_co", 64'(d_co), 64'h0);
      chk("mrst_v", 64'(d_v), 64'h0);
      chk("mrst_ir", 64'(d_ir), 64'h1);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1 chk("mrst_ghost", 64'(d_ov), 64'h0);
      end

      go = 1'b1;
      for (int c = 0; c < 2000 && done < 60; c++) @(posedge clk);
      chk("sweep_done", 64'(done), 64'd60);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
